// File: rtl/gray_seq_checker.sv
// gray_seq_checker: registers incoming Gray codes and decodes each one to binary.
// It classifies each step from the previous accepted code as up, down, hold, or
// illegal (two or more bits changed). Illegal steps are tallied in a saturating
// error counter. All outputs are registered, so no input reaches an output
// without passing through a flop.
module gray_seq_checker #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  gray_in,
    input  logic          clr_err,
    output logic          out_valid,
    output logic [W-1:0]  bin_out,
    output logic          dir_up,
    output logic          dir_dn,
    output logic          step_err,
    output logic [CW-1:0] err_count
);

    typedef enum logic {
        EMPTY = 1'b0,   // no previous sample held
        TRACK = 1'b1    // prev holds the last accepted Gray code
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   prev;

    // Next values for the registered outputs.
    logic [W-1:0]   bin_nxt;
    logic           up_nxt;
    logic           dn_nxt;
    logic           err_nxt;
    logic [CW-1:0]  count_nxt;

    // Intermediate decode and step-classification values.
    logic [W-1:0]   prev_bin;
    logic [W-1:0]   diff;
    logic           one_bit;
    logic           multi_bit;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking, so all flops sample
        // pre-edge values and simulation matches the synthesized hardware.
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: any accepted sample means a previous code is now held.
    always_comb begin
        state_nxt = state;
        if (in_valid) begin
            state_nxt = TRACK;
        end
    end

    // Output logic: classify the step from prev to gray_in and prepare register inputs.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves a signal unassigned and no latch is inferred.
        bin_nxt   = bin_out;
        up_nxt    = 1'b0;
        dn_nxt    = 1'b0;
        err_nxt   = 1'b0;
        count_nxt = err_count;

        prev_bin  = gray2bin(prev);
        diff      = gray_in ^ prev;
        // A non-zero value with a single set bit satisfies (d & (d-1)) == 0.
        one_bit   = (diff != '0) && ((diff & (diff - W'(1))) == '0);
        multi_bit = (diff != '0) && !one_bit;

        if (in_valid) begin
            bin_nxt = gray2bin(gray_in);
            if (state == TRACK) begin
                if (one_bit) begin
                    // Adjacent codes differ by exactly 1 in binary; wrap-around
                    // falls out of the modulo-2^W addition.
                    if (bin_nxt == prev_bin + W'(1)) begin
                        up_nxt = 1'b1;
                    end else begin
                        dn_nxt = 1'b1;
                    end
                end else if (multi_bit) begin
                    err_nxt = 1'b1;
                end
            end
        end

        // A clear that coincides with a new error leaves that error counted.
        if (clr_err) begin
            count_nxt = err_nxt ? CW'(1) : '0;
        end else if (err_nxt && (err_count != '1)) begin
            count_nxt = err_count + CW'(1);
        end
    end

    // Output and history registers. bin_out and prev hold across gaps in in_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            bin_out   <= '0;
            dir_up    <= 1'b0;
            dir_dn    <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
            prev      <= '0;
        end else begin
            out_valid <= in_valid;
            bin_out   <= bin_nxt;
            dir_up    <= up_nxt;
            dir_dn    <= dn_nxt;
            step_err  <= err_nxt;
            err_count <= count_nxt;
            if (in_valid) begin
                prev <= gray_in;
            end
        end
    end

endmodule

// File: tb/tb_gray_seq_checker.sv
// Testbench for gray_seq_checker. It uses directed Gray-code sequences with
// hand-computed expectations. A CW=8 instance covers the main behaviour.
// A CW=2 instance driven by the same inputs covers counter saturation.
module tb_gray_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] gray_in;
    logic       clr_err;

    logic       out_valid,   out_valid_s;
    logic [3:0] bin_out,     bin_out_s;
    logic       dir_up,      dir_up_s;
    logic       dir_dn,      dir_dn_s;
    logic       step_err,    step_err_s;
    logic [7:0] err_count;
    logic [1:0] err_count_s;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    gray_seq_checker #(.W(4), .CW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .gray_in   (gray_in),
        .clr_err   (clr_err),
        .out_valid (out_valid),
        .bin_out   (bin_out),
        .dir_up    (dir_up),
        .dir_dn    (dir_dn),
        .step_err  (step_err),
        .err_count (err_count)
    );

    gray_seq_checker #(.W(4), .CW(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .gray_in   (gray_in),
        .clr_err   (clr_err),
        .out_valid (out_valid_s),
        .bin_out   (bin_out_s),
        .dir_up    (dir_up_s),
        .dir_dn    (dir_dn_s),
        .step_err  (step_err_s),
        .err_count (err_count_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Compare every output of the main instance against the expected values.
    task automatic expect_out(input string tag, input logic ov, input logic [3:0] bin,
                              input logic up, input logic dn, input logic se,
                              input logic [7:0] ec);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".bin_out"},   32'(bin_out),   32'(bin));
        check({tag, ".dir_up"},    32'(dir_up),    32'(up));
        check({tag, ".dir_dn"},    32'(dir_dn),    32'(dn));
        check({tag, ".step_err"},  32'(step_err),  32'(se));
        check({tag, ".err_count"}, 32'(err_count), 32'(ec));
    endtask

    // Drive one cycle of stimulus, then sample just after the capturing edge.
    task automatic step(input logic v, input logic [3:0] g, input logic c);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = v;
        gray_in  = g;
        clr_err  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        gray_in  = 4'b0000;
        clr_err  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        gray_in  = 4'b0000;
        clr_err  = 1'b0;

        // Reset has priority over a valid sample; outputs stay zero.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst      = 1'b1;
            in_valid = 1'b1;
            gray_in  = 4'b1111;
            @(posedge clk);
            #1;
            expect_out($sformatf("rst%0d", i), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        // First sample after reset: 1111 decodes to 1010 and raises no flags.
        step(1'b1, 4'b1111, 1'b0);
        expect_out("rst_first", 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 8'd0);

        // Up sequence 0..4.
        do_reset();
        step(1'b1, 4'b0000, 1'b0); expect_out("up0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'b0001, 1'b0); expect_out("up1", 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'b0011, 1'b0); expect_out("up2", 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'b0010, 1'b0); expect_out("up3", 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'b0110, 1'b0); expect_out("up4", 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 8'd0);

        // Wrap-around up (15->0), hold, then wrap-around down (0->15).
        do_reset();
        step(1'b1, 4'b1000, 1'b0); expect_out("wrap15",   1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'b0000, 1'b0); expect_out("wrap_up",  1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'b0000, 1'b0); expect_out("wrap_hld", 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'b1000, 1'b0); expect_out("wrap_dn",  1'b1, 4'd15, 1'b0, 1'b1, 1'b0, 8'd0);

        // Hold across an in_valid gap.
        do_reset();
        step(1'b1, 4'b0011, 1'b0); expect_out("gap_a",  1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 4'b1111, 1'b0); expect_out("gap_b",  1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 4'b0101, 1'b0); expect_out("gap_c",  1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'b0011, 1'b0); expect_out("gap_d",  1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 8'd0);

        // Illegal step 0011->0101 (bin 6), then resync and step up 6->7.
        step(1'b1, 4'b0101, 1'b0); expect_out("ill_err", 1'b1, 4'd6, 1'b0, 1'b0, 1'b1, 8'd1);
        step(1'b1, 4'b0100, 1'b0); expect_out("ill_up",  1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 8'd1);

        // Saturation on the CW=2 instance; the CW=8 instance keeps counting.
        do_reset();
        step(1'b1, 4'b0000, 1'b0);
        check("sat_init", 32'(err_count_s), 32'd0);
        step(1'b1, 4'b0011, 1'b0);
        check("sat1", 32'(err_count_s), 32'd1); check("sat1_w8", 32'(err_count), 32'd1);
        step(1'b1, 4'b0000, 1'b0);
        check("sat2", 32'(err_count_s), 32'd2); check("sat2_w8", 32'(err_count), 32'd2);
        step(1'b1, 4'b0011, 1'b0);
        check("sat3", 32'(err_count_s), 32'd3); check("sat3_w8", 32'(err_count), 32'd3);
        step(1'b1, 4'b0000, 1'b0);
        check("sat4", 32'(err_count_s), 32'd3); check("sat4_w8", 32'(err_count), 32'd4);
        check("sat4_flag", 32'(step_err_s), 32'd1);
        // A clear in the same cycle as a new error leaves a count of one.
        step(1'b1, 4'b0011, 1'b1);
        check("clr_err_s", 32'(err_count_s), 32'd1); check("clr_err_w8", 32'(err_count), 32'd1);
        // A clear with no new error returns the count to zero.
        step(1'b0, 4'b0000, 1'b1);
        check("clr_only_s", 32'(err_count_s), 32'd0); check("clr_only_w8", 32'(err_count), 32'd0);

        // Reset mid-stream: the next sample is treated as the first.
        step(1'b1, 4'b0101, 1'b0);
        do_reset();
        expect_out("mid_rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 4'b1010, 1'b0);
        expect_out("mid_first", 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
